// File: rtl/kernel_accumulator.sv
// Sequential SIZE x SIZE multiply-accumulate over an 8-bit pixel window and Q0.8 kernel.
// Consumes one element per enabled cycle; result is acc>>8 saturated to 8 bits.
module kernel_accumulator #(
  parameter logic [3:0] SIZE = 4'd3
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]   in,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]   kernel,
  input  logic                             en_strobe,
  output logic [3:0]                       cur_x,
  output logic [3:0]                       cur_y,
  input  logic                             clear,
  input  logic                             start,
  output logic                             ready,
  output logic [7:0]                       sum
);

  typedef enum logic {StIdle, StAccum} state_e;

  localparam logic [3:0] LAST = SIZE - 4'd1;

  state_e      r_state, w_state_d;
  logic [3:0]  r_x, w_x_d;
  logic [3:0]  r_y, w_y_d;
  logic [23:0] r_acc, w_acc_d;
  logic [7:0]  r_sum, w_sum_d;

  logic [7:0]  w_pix;
  logic [7:0]  w_wgt;
  logic [15:0] w_prod;
  logic [23:0] w_acc_sum;
  logic [15:0] w_scaled;
  logic        w_last;

  // Element select by loop compare keeps index widths exact for any SIZE.
  always_comb begin
    w_pix = 8'd0;
    w_wgt = 8'd0;
    for (int y = 0; y < int'(SIZE); y++) begin
      for (int x = 0; x < int'(SIZE); x++) begin
        if (r_y == 4'(y) && r_x == 4'(x)) begin
          w_pix = in[y][x];
          w_wgt = kernel[y][x];
        end
      end
    end
  end

  assign w_prod    = 16'(w_pix) * 16'(w_wgt);
  assign w_acc_sum = r_acc + 24'(w_prod);
  assign w_scaled  = w_acc_sum[23:8];
  assign w_last    = (r_x == LAST) && (r_y == LAST);

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_acc_d   = r_acc;
    w_sum_d   = r_sum;
    if (clear) begin
      w_state_d = StIdle;
      w_x_d     = 4'd0;
      w_y_d     = 4'd0;
      w_acc_d   = 24'd0;
      w_sum_d   = 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_state_d = StAccum;
            w_x_d     = 4'd0;
            w_y_d     = 4'd0;
            w_acc_d   = 24'd0;
          end
        end
        StAccum: begin
          if (en_strobe) begin
            w_acc_d = w_acc_sum;
            if (w_last) begin
              w_state_d = StIdle;
              w_x_d     = 4'd0;
              w_y_d     = 4'd0;
              w_sum_d   = (w_scaled > 16'd255) ? 8'd255 : w_scaled[7:0];
            end else if (r_x == LAST) begin
              w_x_d = 4'd0;
              w_y_d = r_y + 4'd1;
            end else begin
              w_x_d = r_x + 4'd1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
      r_x     <= 4'd0;
      r_y     <= 4'd0;
      r_acc   <= 24'd0;
      r_sum   <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_acc   <= w_acc_d;
      r_sum   <= w_sum_d;
    end
  end

  assign cur_x = r_x;
  assign cur_y = r_y;
  assign ready = (r_state == StIdle);
  assign sum   = r_sum;

endmodule

// File: tb/tb_kernel_accumulator.sv
// Directed bench for kernel_accumulator (SIZE=3) with hand-computed expected sums.
module tb_kernel_accumulator;

  logic                  clk;
  logic                  n_rst;
  logic [2:0][2:0][7:0]  in;
  logic [2:0][2:0][7:0]  kernel;
  logic                  en_strobe;
  logic [3:0]            cur_x;
  logic [3:0]            cur_y;
  logic                  clear;
  logic                  start;
  logic                  ready;
  logic [7:0]            sum;

  int n_checks = 0;
  int n_errors = 0;

  kernel_accumulator #(.SIZE(4'd3)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in        (in),
    .kernel    (kernel),
    .en_strobe (en_strobe),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .clear     (clear),
    .start     (start),
    .ready     (ready),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] pix, input logic [7:0] wgt);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        in[y][x]     = pix;
        kernel[y][x] = wgt;
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs with en_strobe high for 9 cycles, then checks completion.
  task automatic run_full(input string tag, input logic [7:0] exp_sum);
    do_start();
    check({tag, "_busy"}, ready, 1'b0);
    en_strobe = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    en_strobe = 1'b0;
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_sum"}, sum, exp_sum);
  endtask

  initial begin
    n_rst = 1'b0; en_strobe = 1'b0; clear = 1'b0; start = 1'b0;
    fill(8'd0, 8'd0);
    #12;
    n_rst = 1'b1;
    tick();
    check("rst_ready", ready, 1'b1);
    check("rst_sum", sum, 8'd0);
    check("rst_x", cur_x, 4'd0);
    check("rst_y", cur_y, 4'd0);

    // 255*28*9 = 64260 -> 251, with index walk
    fill(8'd255, 8'd28);
    do_start();
    check("walk_busy", ready, 1'b0);
    en_strobe = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("walk_x%0d", k), cur_x, 4'(k % 3));
      check($sformatf("walk_y%0d", k), cur_y, 4'(k / 3));
      if (k < 8) check($sformatf("walk_rdy%0d", k), ready, 1'b0);
      tick();
    end
    en_strobe = 1'b0;
    check("walk_ready", ready, 1'b1);
    check("walk_sum", sum, 8'd251);
    check("walk_x_end", cur_x, 4'd0);
    check("walk_y_end", cur_y, 4'd0);

    // Centre-only kernel: 200*255 = 51000 -> 199
    fill(8'd0, 8'd0);
    in[1][1] = 8'd200;
    kernel[1][1] = 8'd255;
    run_full("ident", 8'd199);

    // 585225>>8 = 2286 -> saturates
    fill(8'd255, 8'd255);
    run_full("sat", 8'd255);

    // Alternating enable: same result, 18 cycles
    fill(8'd255, 8'd28);
    do_start();
    for (int i = 0; i < 18; i++) begin
      en_strobe = (i % 2 == 0);
      tick();
      if (i == 1) begin
        check("tog_hold_x", cur_x, 4'd1);
        check("tog_hold_y", cur_y, 4'd0);
      end
      if (i == 15) check("tog_busy", ready, 1'b0);
      if (i == 15) check("tog_sum_held", sum, 8'd255);
    end
    en_strobe = 1'b0;
    check("tog_ready", ready, 1'b1);
    check("tog_sum", sum, 8'd251);

    // Start during ACCUM ignored, then clear after 4 elements
    do_start();
    en_strobe = 1'b1;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    en_strobe = 1'b0;
    check("ign_x", cur_x, 4'd1);
    check("ign_y", cur_y, 4'd1);
    check("ign_busy", ready, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ready", ready, 1'b1);
    check("clr_sum", sum, 8'd0);
    check("clr_x", cur_x, 4'd0);
    check("clr_y", cur_y, 4'd0);

    // Clear beats start in the same cycle
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_ready", ready, 1'b1);

    // Sum after restart reflects new data, then async reset mid-run
    run_full("rerun", 8'd251);
    do_start();
    en_strobe = 1'b1;
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_ready", ready, 1'b1);
    check("arst_sum", sum, 8'd0);
    check("arst_x", cur_x, 4'd0);
    check("arst_y", cur_y, 4'd0);
    en_strobe = 1'b0;
    n_rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
